fft_frame_sequencer: RTL and testbench
======================================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter N, default 64: FFT frame length in samples; power of two, 8..256.
REQ-002 Parameter FFT_LAT, default 64: cycles from the FFT's first valid input sample to its first output sample; range 1..1023.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous and active-low.
REQ-005 clr  input  1  synchronous abort; discards the current frame and returns to IDLE.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_ready  output  1  sequencer accepts a sample this cycle.
REQ-008 in_re, in_im  input  16 each  upstream sample, two's complement.
REQ-009 fft_start  output  1  one-cycle start pulse to the FFT core.
REQ-010 fft_valid  output  1  FFT input-sample valid.
REQ-011 fft_re, fft_im  output  16 each  sample to the FFT core.
REQ-012 fft_out_re, fft_out_im  input  16 each  FFT core result.
REQ-013 out_valid, out_last  output  1 each  result valid; last bin of frame.
REQ-014 out_idx  output  log2(N)  bin index of the current result.
REQ-015 out_re, out_im  output  16 each  registered copy of fft_out_re/fft_out_im.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 frame_cnt  output  8  completed output frames, wraps 255->0.

Function
REQ-018 FSM states: IDLE, FILL, START, STREAM, DRAIN.
REQ-019 IDLE->FILL on the first in_valid; that sample is accepted in the same cycle.
REQ-020 in_ready is 1 in IDLE and FILL and 0 in all other states; a sample is written when in_valid&in_ready, at address wr_ptr, and wr_ptr increments.
REQ-021 FILL->START in the cycle after the Nth write; wr_ptr wraps to 0.
REQ-022 START lasts one cycle with fft_start=1, then transitions to STREAM.
REQ-023 STREAM lasts exactly N cycles with fft_valid=1 and buffer entries 0..N-1 presented in order; there are no gaps, because the core cannot stall.
REQ-024 fft_re/fft_im are 0 whenever fft_valid=0.
REQ-025 Output timing: out_valid=1 for N consecutive cycles, starting FFT_LAT+1 cycles after the first STREAM cycle; the extra cycle is the output register.
REQ-026 out_idx counts 0..N-1, and out_last=1 only when out_idx=N-1.
REQ-027 A latency counter runs from the first STREAM cycle; it is independent of the state, so STREAM and the output window may overlap.
REQ-028 STREAM->DRAIN after its Nth cycle; DRAIN->IDLE in the cycle after out_last.
REQ-029 frame_cnt increments on the out_last cycle.
REQ-030 There is no output backpressure; the consumer accepts every out_valid cycle.
REQ-031 clr has priority over all transitions: the next state is IDLE, and pointers, latency counter, out_valid and out_last are cleared; frame_cnt and buffer contents are kept.
REQ-032 in_valid during START/STREAM/DRAIN is ignored (in_ready=0), and no sample is written.
REQ-033 The sample buffer is an N-deep x 32-bit array and is not reset.

Reset
REQ-034 nrst=0 forces: state IDLE, all pointers/counters 0, frame_cnt 0.
REQ-035 nrst=0 drives every output to 0 except in_ready, which is 1.
REQ-036 Assertion of nrst mid-frame abandons the frame with no further fft_valid or out_valid.
REQ-037 The first state change after nrst rises occurs no earlier than the second clk edge.

Structure
REQ-038 A shared package fft_pkg holds: DATA_W=16, the default N and FFT_LAT, and the state encoding constants.
REQ-039 One sub-module, fft_frame_buf, implements the single-port-write / single-port-read N x 32 storage.
REQ-040 The FSM, pointers and latency counter reside in the top level.

Verification
REQ-041 Continuous in_valid with samples re=k, im=-k, k=0..63 -> in_ready falls after 64 accepts; fft_start pulses once; fft_valid is high for 64 cycles carrying re=0..63 in order.
REQ-042 Loopback stub core with a FFT_LAT=64 delay -> out_valid rises exactly 65 cycles after the first fft_valid; out_idx=0..63; out_last at idx 63; frame_cnt=1.
REQ-043 in_valid toggling 1/0 during FILL -> 64 accepts take 127 cycles; streamed order is unchanged and contiguous.
REQ-044 clr asserted on the 10th STREAM cycle -> the next cycle shows IDLE, fft_valid=0, no out_valid, frame_cnt unchanged; a following frame completes normally.
REQ-045 nrst pulsed low during DRAIN -> all outputs 0 and in_ready=1 asynchronously; frame_cnt=0.
REQ-046 Three back-to-back frames with FFT_LAT=10 (output overlapping STREAM) -> 192 results are in order; frame_cnt=3; in_ready stays 0 from START until DRAIN exits.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, defaults and state encoding for the FFT frame sequencer
package fft_pkg;
    localparam int DATA_W          = 16;
    localparam int N_DEFAULT       = 64;
    localparam int FFT_LAT_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_START  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;
endpackage

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - N x {re,im} frame storage, one write port and one asynchronous read port
// Contents are deliberately not reset; every entry is rewritten before it is streamed.
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = $clog2(N)
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [2*DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]       i_rd_addr,
    output logic [2*DATA_W-1:0] o_rd_data
);
    logic [2*DATA_W-1:0] r_mem [N];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - collects N samples, streams them gap-free to an FFT core and frames its results
// The latency counter is decoupled from the FSM so the output window may overlap STREAM.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int FFT_LAT = FFT_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_re,
    input  logic [DATA_W-1:0]    in_im,
    output logic                 fft_start,
    output logic                 fft_valid,
    output logic [DATA_W-1:0]    fft_re,
    output logic [DATA_W-1:0]    fft_im,
    input  logic [DATA_W-1:0]    fft_out_re,
    input  logic [DATA_W-1:0]    fft_out_im,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [DATA_W-1:0]    out_re,
    output logic [DATA_W-1:0]    out_im,
    output logic                 busy,
    output logic [7:0]           frame_cnt
);
    localparam int IDX_W = $clog2(N);
    localparam int LAT_W = $clog2(FFT_LAT + N + 1);
    localparam logic [LAT_W-1:0] LAT_FIRST = LAT_W'(FFT_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(FFT_LAT + N - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);

    state_t              r_state, w_next;
    logic                r_arm;
    logic [IDX_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic                r_lat_run;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_out_valid, r_out_last;
    logic [IDX_W-1:0]    r_out_idx;
    logic [DATA_W-1:0]   r_out_re, r_out_im;
    logic [7:0]          r_frame_cnt;
    logic                w_accept, w_fill_done, w_stream_done, w_cap;
    logic [IDX_W-1:0]    w_cap_idx;
    logic [2*DATA_W-1:0] w_rd_data;

    fft_frame_buf #(.N(N), .AW(IDX_W)) u_buf (
        .i_clk     (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({in_re, in_im}),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign w_accept      = in_valid && in_ready && !clr;
    assign w_fill_done   = w_accept && (r_wr_ptr == IDX_LAST);
    assign w_stream_done = (r_state == ST_STREAM) && (r_rd_ptr == IDX_LAST);
    assign w_cap         = r_lat_run && (r_lat_cnt >= LAT_FIRST) && (r_lat_cnt <= LAT_LAST);
    assign w_cap_idx     = IDX_W'(r_lat_cnt - LAT_FIRST);

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        fft_start = 1'b0;
        fft_valid = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_next = ST_FILL;
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (w_fill_done) w_next = ST_START;
            end
            ST_START: begin
                fft_start = 1'b1;
                w_next    = ST_STREAM;
            end
            ST_STREAM: begin
                fft_valid = 1'b1;
                if (w_stream_done) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_out_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (clr) w_next = ST_IDLE;
    end

    // r_arm holds the FSM for one edge after reset release.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_arm   <= 1'b0;
        end else begin
            r_arm <= 1'b1;
            if (r_arm) r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_lat_run   <= 1'b0;
            r_lat_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_frame_cnt <= '0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_lat_run   <= 1'b0;
            r_lat_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            // N is a power of two, so both pointers wrap to 0 on their own.
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_state == ST_STREAM) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_state == ST_START) begin
                r_lat_run <= 1'b1;
                r_lat_cnt <= '0;
            end else if (r_lat_run) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
                if (r_lat_cnt == LAT_LAST) r_lat_run <= 1'b0;
            end
            r_out_valid <= w_cap;
            r_out_last  <= w_cap && (w_cap_idx == IDX_LAST);
            r_out_idx   <= w_cap ? w_cap_idx : '0;
            r_out_re    <= w_cap ? fft_out_re : '0;
            r_out_im    <= w_cap ? fft_out_im : '0;
            if (r_out_last) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign fft_re    = fft_valid ? w_rd_data[2*DATA_W-1:DATA_W] : '0;
    assign fft_im    = fft_valid ? w_rd_data[DATA_W-1:0] : '0;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_idx   = r_out_idx;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - scoreboard bench: two sequencers (FFT_LAT 64 and 10) with loopback delay-line cores
module tb_fft_frame_sequencer;
    localparam int NS   = 64;
    localparam int LAT0 = 64;
    localparam int LAT1 = 10;

    typedef struct packed {
        logic [5:0]  idx;
        logic        last;
        logic [15:0] re;
        logic [15:0] im;
    } out_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        clr       [2];
    logic        in_valid  [2];
    logic [15:0] in_re     [2];
    logic [15:0] in_im     [2];
    logic        in_ready  [2];
    logic        fft_start [2];
    logic        fft_valid [2];
    logic [15:0] fft_re    [2];
    logic [15:0] fft_im    [2];
    logic [15:0] fft_out_re[2];
    logic [15:0] fft_out_im[2];
    logic        out_valid [2];
    logic        out_last  [2];
    logic [5:0]  out_idx   [2];
    logic [15:0] out_re    [2];
    logic [15:0] out_im    [2];
    logic        busy      [2];
    logic [7:0]  frame_cnt [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    out_t        q_out0[$];
    out_t        q_out1[$];
    logic [31:0] q_fft0[$];
    logic [31:0] q_fft1[$];
    int run[2];
    int start_cnt[2];
    int t_first[2];
    bit abort[2];
    bit locked[2];
    bit prev_fv[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        logic [31:0] dly [LAT];

        fft_frame_sequencer #(.N(NS), .FFT_LAT(LAT)) u_dut (
            .clk        (clk),
            .nrst       (nrst),
            .clr        (clr[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_re      (in_re[g]),
            .in_im      (in_im[g]),
            .fft_start  (fft_start[g]),
            .fft_valid  (fft_valid[g]),
            .fft_re     (fft_re[g]),
            .fft_im     (fft_im[g]),
            .fft_out_re (fft_out_re[g]),
            .fft_out_im (fft_out_im[g]),
            .out_valid  (out_valid[g]),
            .out_last   (out_last[g]),
            .out_idx    (out_idx[g]),
            .out_re     (out_re[g]),
            .out_im     (out_im[g]),
            .busy       (busy[g]),
            .frame_cnt  (frame_cnt[g])
        );

        always @(posedge clk) begin
            dly[0] <= {fft_re[g], fft_im[g]};
            for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
        end
        assign fft_out_re[g] = dly[LAT-1][31:16];
        assign fft_out_im[g] = dly[LAT-1][15:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_nonempty(input string name, input int size);
        checks++;
        if (size == 0) begin
            errors++;
            $display("FAIL %s: DUT output with no expected entry queued at t=%0t", name, $time);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever a DUT presents data.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            out_t        e;
            logic [31:0] f;
            int          sz;
            if (!nrst) locked[g] = 1'b0;
            if (locked[g]) chk("in_ready_locked", 32'(in_ready[g]), 0);
            if (fft_start[g]) begin
                start_cnt[g]++;
                locked[g] = 1'b1;
            end
            if (clr[g] || out_last[g]) locked[g] = 1'b0;

            if (fft_valid[g]) begin
                if (!prev_fv[g]) t_first[g] = cyc;
                run[g]++;
                sz = (g == 0) ? q_fft0.size() : q_fft1.size();
                chk_nonempty("fft_q", sz);
                if (sz > 0) begin
                    if (g == 0) f = q_fft0.pop_front();
                    else        f = q_fft1.pop_front();
                    chk("fft_sample", {fft_re[g], fft_im[g]}, f);
                end
            end else begin
                chk("fft_data_zero", {fft_re[g], fft_im[g]}, 0);
                if (run[g] > 0 && !abort[g]) chk("fft_run_len", run[g], NS);
                if (run[g] > 0) begin
                    run[g]   = 0;
                    abort[g] = 1'b0;
                end
            end
            prev_fv[g] = fft_valid[g];

            if (out_valid[g]) begin
                sz = (g == 0) ? q_out0.size() : q_out1.size();
                chk_nonempty("out_q", sz);
                if (sz > 0) begin
                    if (g == 0) e = q_out0.pop_front();
                    else        e = q_out1.pop_front();
                    chk("out_idx", 32'(out_idx[g]), 32'(e.idx));
                    chk("out_re", 32'(out_re[g]), 32'(e.re));
                    chk("out_im", 32'(out_im[g]), 32'(e.im));
                    chk("out_last", 32'(out_last[g]), 32'(e.last));
                    if (e.idx == 6'd0)
                        chk("out_latency", cyc - t_first[g], ((g == 0) ? LAT0 : LAT1) + 1);
                end
            end else begin
                chk("out_last_idle", 32'(out_last[g]), 0);
            end
        end
    end

    task automatic set_in(input int sel, input logic v, input logic [15:0] re, input logic [15:0] im);
        in_valid[sel] = v;
        in_re[sel]    = re;
        in_im[sel]    = im;
    endtask

    task automatic push_exp(input int sel, input int k, input logic [15:0] re, input logic [15:0] im,
                            input bit exp_out);
        out_t e;
        e.idx  = 6'(k);
        e.last = (k == NS - 1);
        e.re   = re;
        e.im   = im;
        if (sel == 0) begin
            q_fft0.push_back({re, im});
            if (exp_out) q_out0.push_back(e);
        end else begin
            q_fft1.push_back({re, im});
            if (exp_out) q_out1.push_back(e);
        end
    endtask

    // Leaves the last sample driven; the caller's next edge accepts it.
    task automatic send_frame(input int sel, input int base, input bit gap, input bit exp_out,
                              output int span);
        int          k       = 0;
        int          budget  = 0;
        int          c_first = 0;
        int          c_last  = 0;
        bit          skip    = 1'b0;
        logic [15:0] re, im;
        while (k < NS && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
            if (gap && skip) begin
                set_in(sel, 1'b0, 16'd0, 16'd0);
                skip = 1'b0;
            end else begin
                re = 16'(base + k);
                im = 16'(-(base + k));
                set_in(sel, 1'b1, re, im);
                if (in_ready[sel]) begin
                    if (k == 0) c_first = cyc;
                    c_last = cyc;
                    push_exp(sel, k, re, im, exp_out);
                    k++;
                    skip = 1'b1;
                end
            end
        end
        chk("fill_accepts", k, NS);
        span = c_last - c_first + 1;
    endtask

    task automatic wait_drain(input int sel);
        int n = 0;
        while (((sel == 0) ? q_out0.size() : q_out1.size()) != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", (sel == 0) ? q_out0.size() : q_out1.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int span;
        int n;
        nrst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            clr[g] = 1'b0;
            set_in(g, 1'b0, 16'd0, 16'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready[0]), 1);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_fft_start", 32'(fft_start[0]), 0);
        chk("rst_fft_valid", 32'(fft_valid[0]), 0);
        chk("rst_out_valid", 32'(out_valid[0]), 0);
        chk("rst_frame_cnt", 32'(frame_cnt[0]), 0);
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Continuous fill, re=k im=-k, loopback output with FFT_LAT=64.
        send_frame(0, 0, 1'b0, 1'b1, span);
        @(posedge clk); #1;
        chk("in_ready_after_fill", 32'(in_ready[0]), 0);
        chk("fft_start_pulse", 32'(fft_start[0]), 1);
        set_in(0, 1'b0, 16'd0, 16'd0);
        @(posedge clk); #1;
        chk("fft_start_one_cycle", 32'(fft_start[0]), 0);
        chk("fft_valid_first", 32'(fft_valid[0]), 1);
        wait_drain(0);
        chk("fill_span_cont", span, 64);
        chk("frame_cnt_1", 32'(frame_cnt[0]), 1);
        chk("busy_after_frame", 32'(busy[0]), 0);
        chk("start_cnt_1", start_cnt[0], 1);

        // in_valid toggling during fill.
        send_frame(0, 100, 1'b1, 1'b1, span);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'd0, 16'd0);
        chk("fill_span_toggle", span, 127);
        wait_drain(0);
        chk("frame_cnt_2", 32'(frame_cnt[0]), 2);

        // clr on the 10th STREAM cycle.
        send_frame(0, 200, 1'b0, 1'b0, span);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'd0, 16'd0);
        n = 0;
        while (!fft_valid[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stream_seen", 32'(fft_valid[0]), 1);
        repeat (9) begin
            @(posedge clk); #1;
        end
        abort[0] = 1'b1;
        clr[0]   = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        chk("clr_busy", 32'(busy[0]), 0);
        chk("clr_fft_valid", 32'(fft_valid[0]), 0);
        chk("clr_out_valid", 32'(out_valid[0]), 0);
        chk("clr_in_ready", 32'(in_ready[0]), 1);
        chk("clr_frame_cnt", 32'(frame_cnt[0]), 2);
        q_fft0.delete();
        repeat (150) @(posedge clk);
        #1;
        send_frame(0, 300, 1'b0, 1'b1, span);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'd0, 16'd0);
        wait_drain(0);
        chk("frame_cnt_after_clr", 32'(frame_cnt[0]), 3);
        chk("start_cnt_4", start_cnt[0], 4);

        // Three back-to-back frames, FFT_LAT=10 so output overlaps STREAM.
        send_frame(1, 1000, 1'b0, 1'b1, span);
        send_frame(1, 1064, 1'b0, 1'b1, span);
        send_frame(1, 1128, 1'b0, 1'b1, span);
        @(posedge clk); #1;
        set_in(1, 1'b0, 16'd0, 16'd0);
        wait_drain(1);
        chk("b2b_frame_cnt", 32'(frame_cnt[1]), 3);
        chk("b2b_start_cnt", start_cnt[1], 3);

        // nrst pulsed in the middle of the output window (DRAIN).
        send_frame(0, 400, 1'b0, 1'b1, span);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'd0, 16'd0);
        n = 0;
        while (!fft_valid[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (fft_valid[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_reached", 32'(busy[0]), 1);
        repeat (20) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready[0]), 1);
        chk("arst_busy", 32'(busy[0]), 0);
        chk("arst_fft_start", 32'(fft_start[0]), 0);
        chk("arst_fft_valid", 32'(fft_valid[0]), 0);
        chk("arst_out_valid", 32'(out_valid[0]), 0);
        chk("arst_out_last", 32'(out_last[0]), 0);
        chk("arst_out_idx", 32'(out_idx[0]), 0);
        chk("arst_out_data", {out_re[0], out_im[0]}, 0);
        chk("arst_frame_cnt", 32'(frame_cnt[0]), 0);
        q_out0.delete();
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("end_q_out0", q_out0.size(), 0);
        chk("end_q_out1", q_out1.size(), 0);
        chk("end_q_fft0", q_fft0.size(), 0);
        chk("end_q_fft1", q_fft1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
